// File: rtl/src_datapath_if.sv
// Control and observation bundle for the Mini SRC single-bus datapath.
// The control unit (or bench) drives it as master; the datapath consumes it as slave.
interface src_datapath_if;
    logic        incPC;
    logic [3:0]  GP_addr;
    logic [31:0] Mdatain;
    logic        MDR_read;
    logic        e_PC;
    logic        e_IR;
    logic        e_Y;
    logic        e_HI;
    logic        e_LO;
    logic        e_MAR;
    logic        e_MDR;
    logic        e_Z;
    logic        e_GP;
    logic [3:0]  ALU_op;
    logic [4:0]  BusDataSelect;
    logic [31:0] BusMuxOut;
    logic [31:0] MARout;

    modport master (
        output incPC, GP_addr, Mdatain, MDR_read,
        output e_PC, e_IR, e_Y, e_HI, e_LO, e_MAR, e_MDR, e_Z, e_GP,
        output ALU_op, BusDataSelect,
        input  BusMuxOut, MARout
    );

    modport slave (
        input  incPC, GP_addr, Mdatain, MDR_read,
        input  e_PC, e_IR, e_Y, e_HI, e_LO, e_MAR, e_MDR, e_Z, e_GP,
        input  ALU_op, BusDataSelect,
        output BusMuxOut, MARout
    );
endinterface

// File: rtl/src_datapath.sv
// Mini SRC single-bus datapath: R0-R15, PC, IR, Y, Z(64b), HI, LO, MAR, MDR,
// a combinational bus multiplexer and an ALU with A=Y and B=bus.
module src_datapath (
    input  logic           clock,
    input  logic           clear,
    src_datapath_if.slave  dp
);
    logic [31:0] gp_q [16];
    logic [31:0] pc_q, ir_q, y_q, hi_q, lo_q, mar_q, mdr_q;
    logic [63:0] z_q;

    logic [31:0] bus_s;
    logic [63:0] alu_s;
    logic [63:0] z_d;
    logic [31:0] mdr_d;
    logic [4:0]  sh_s;
    logic [63:0] mul_s;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic [63:0] rol_s;
    logic [63:0] ror_s;

    assign sh_s  = bus_s[4:0];
    assign mul_s = $signed({{32{y_q[31]}}, y_q}) * $signed({{32{bus_s[31]}}, bus_s});
    // Rotations shift a doubled copy so a zero amount needs no special case.
    assign rol_s = {y_q, y_q} << sh_s;
    assign ror_s = {y_q, y_q} >> sh_s;

    // Signed divide; a zero divisor is steered away from the divider.
    always_comb begin
        quo_s = 32'd0;
        rem_s = 32'd0;
        if (bus_s != 32'd0) begin
            quo_s = $signed(y_q) / $signed(bus_s);
            rem_s = $signed(y_q) % $signed(bus_s);
        end else begin
            quo_s = 32'd0;
            rem_s = 32'd0;
        end
    end

    // Bus source multiplexer.
    always_comb begin
        bus_s = 32'd0;
        if (dp.BusDataSelect[4] == 1'b0) begin
            bus_s = gp_q[dp.BusDataSelect[3:0]];
        end else begin
            case (dp.BusDataSelect[3:0])
                4'd0:    bus_s = hi_q;
                4'd1:    bus_s = lo_q;
                4'd2:    bus_s = z_q[63:32];
                4'd3:    bus_s = z_q[31:0];
                4'd4:    bus_s = pc_q;
                4'd5:    bus_s = mdr_q;
                4'd6:    bus_s = ir_q;
                default: bus_s = 32'd0;
            endcase
        end
    end

    // ALU result; only MUL and DIV produce a non-zero upper half.
    always_comb begin
        alu_s = 64'd0;
        case (dp.ALU_op)
            4'd0:    alu_s = {32'd0, y_q + bus_s};
            4'd1:    alu_s = {32'd0, y_q - bus_s};
            4'd2:    alu_s = {32'd0, y_q & bus_s};
            4'd3:    alu_s = {32'd0, y_q | bus_s};
            4'd4:    alu_s = mul_s;
            4'd5:    alu_s = {rem_s, quo_s};
            4'd6:    alu_s = {32'd0, y_q >> sh_s};
            4'd7:    alu_s = {32'd0, $signed(y_q) >>> sh_s};
            4'd8:    alu_s = {32'd0, y_q << sh_s};
            4'd9:    alu_s = {32'd0, rol_s[63:32]};
            4'd10:   alu_s = {32'd0, ror_s[31:0]};
            4'd11:   alu_s = {32'd0, 32'd0 - bus_s};
            4'd12:   alu_s = {32'd0, ~bus_s};
            default: alu_s = 64'd0;
        endcase
    end

    // Z source and MDR input selection.
    always_comb begin
        z_d   = alu_s;
        mdr_d = bus_s;
        if (dp.incPC) begin
            z_d = {32'd0, bus_s + 32'd1};
        end else begin
            z_d = alu_s;
        end
        if (dp.MDR_read) begin
            mdr_d = dp.Mdatain;
        end else begin
            mdr_d = bus_s;
        end
    end

    // Register file and special registers; clear forces everything to zero immediately.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < 16; i++) gp_q[i] <= 32'd0;
            pc_q  <= 32'd0;
            ir_q  <= 32'd0;
            y_q   <= 32'd0;
            z_q   <= 64'd0;
            hi_q  <= 32'd0;
            lo_q  <= 32'd0;
            mar_q <= 32'd0;
            mdr_q <= 32'd0;
        end else begin
            if (dp.e_GP)  gp_q[dp.GP_addr] <= bus_s;
            if (dp.e_PC)  pc_q  <= bus_s;
            if (dp.e_IR)  ir_q  <= bus_s;
            if (dp.e_Y)   y_q   <= bus_s;
            if (dp.e_Z)   z_q   <= z_d;
            if (dp.e_HI)  hi_q  <= bus_s;
            if (dp.e_LO)  lo_q  <= bus_s;
            if (dp.e_MAR) mar_q <= bus_s;
            if (dp.e_MDR) mdr_q <= mdr_d;
        end
    end

    assign dp.BusMuxOut = bus_s;
    assign dp.MARout    = mar_q;
endmodule

// File: tb/tb_src_datapath.sv
// Directed self-checking bench for src_datapath: reset, ALU ops, fetch, bus sweep.
module tb_src_datapath;
    logic clock;
    logic clear;
    int   n_checks;
    int   n_errors;

    src_datapath_if dp ();

    src_datapath dut (
        .clock (clock),
        .clear (clear),
        .dp    (dp.slave)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic idle();
        dp.incPC    = 1'b0;
        dp.MDR_read = 1'b0;
        dp.e_PC     = 1'b0;
        dp.e_IR     = 1'b0;
        dp.e_Y      = 1'b0;
        dp.e_HI     = 1'b0;
        dp.e_LO     = 1'b0;
        dp.e_MAR    = 1'b0;
        dp.e_MDR    = 1'b0;
        dp.e_Z      = 1'b0;
        dp.e_GP     = 1'b0;
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
        idle();
    endtask

    task automatic chk_bus(input string tag, input logic [4:0] sel, input logic [31:0] exp);
        dp.BusDataSelect = sel;
        #1;
        chk(tag, {32'd0, dp.BusMuxOut}, {32'd0, exp});
    endtask

    task automatic load_mdr(input logic [31:0] val);
        dp.Mdatain  = val;
        dp.MDR_read = 1'b1;
        dp.e_MDR    = 1'b1;
        step();
    endtask

    task automatic put_gp(input logic [3:0] idx, input logic [31:0] val);
        load_mdr(val);
        dp.BusDataSelect = 5'd21;
        dp.GP_addr       = idx;
        dp.e_GP          = 1'b1;
        step();
    endtask

    task automatic alu_chk(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op, input logic inc, input logic [63:0] exp);
        put_gp(4'd14, a);
        put_gp(4'd15, b);
        dp.BusDataSelect = 5'd14;
        dp.e_Y           = 1'b1;
        step();
        dp.BusDataSelect = 5'd15;
        dp.ALU_op        = op;
        dp.incPC         = inc;
        dp.e_Z           = 1'b1;
        step();
        chk_bus({tag, "_lo"}, 5'd19, exp[31:0]);
        chk_bus({tag, "_hi"}, 5'd18, exp[63:32]);
    endtask

    task automatic ror_case(input string tag, input logic [31:0] a, input logic [31:0] exp);
        put_gp(4'd3, a);
        put_gp(4'd7, 32'd8);
        dp.BusDataSelect = 5'd3;
        dp.e_Y           = 1'b1;
        step();
        dp.BusDataSelect = 5'd7;
        dp.ALU_op        = 4'b1010;
        dp.e_Z           = 1'b1;
        step();
        dp.BusDataSelect = 5'd19;
        dp.GP_addr       = 4'd4;
        dp.e_GP          = 1'b1;
        step();
        chk_bus(tag, 5'd4, exp);
    endtask

    logic [31:0] exp_s;

    initial begin
        n_checks         = 0;
        n_errors         = 0;
        clock            = 1'b0;
        clear            = 1'b0;
        dp.GP_addr       = 4'd0;
        dp.Mdatain       = 32'd0;
        dp.ALU_op        = 4'd0;
        dp.BusDataSelect = 5'd0;
        idle();
        @(negedge clock);
        @(negedge clock);
        clear = 1'b1;

        // Asynchronous clear in the middle of a cycle.
        put_gp(4'd5, 32'h0000_1234);
        chk_bus("r5_pre_clear", 5'd5, 32'h0000_1234);
        @(negedge clock);
        #2;
        clear = 1'b0;
        #1;
        chk("r5_async_clear", {32'd0, dp.BusMuxOut}, 64'd0);
        for (int s = 0; s < 32; s++) chk_bus($sformatf("clr_sel%0d", s), s[4:0], 32'd0);
        chk("mar_clear", {32'd0, dp.MARout}, 64'd0);
        @(negedge clock);
        clear = 1'b1;

        ror_case("ror_a5", 32'hA5A5_A5A5, 32'hA5A5_A5A5);
        ror_case("ror_1234", 32'h1234_5678, 32'h7812_3456);

        // Instruction fetch sequence.
        clear = 1'b0;
        #1;
        clear = 1'b1;
        dp.BusDataSelect = 5'd20;
        dp.e_MAR         = 1'b1;
        dp.incPC         = 1'b1;
        dp.e_Z           = 1'b1;
        dp.ALU_op        = 4'b0100;
        step();
        chk("fetch_mar", {32'd0, dp.MARout}, 64'd0);
        chk_bus("fetch_zlo", 5'd19, 32'd1);
        chk_bus("fetch_zhi", 5'd18, 32'd0);
        dp.BusDataSelect = 5'd19;
        dp.e_PC          = 1'b1;
        step();
        chk_bus("fetch_pc", 5'd20, 32'd1);
        load_mdr(32'h2A32_8000);
        dp.BusDataSelect = 5'd21;
        dp.e_IR          = 1'b1;
        step();
        chk_bus("fetch_ir", 5'd22, 32'h2A32_8000);

        alu_chk("mul", 32'hFFFF_FFFE, 32'd3, 4'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFFA);
        alu_chk("div", 32'd7, 32'd2, 4'd5, 1'b0, 64'h0000_0001_0000_0003);
        alu_chk("div0", 32'd7, 32'd0, 4'd5, 1'b0, 64'd0);
        alu_chk("shr", 32'h8000_0001, 32'd1, 4'd6, 1'b0, 64'h0000_0000_4000_0000);
        alu_chk("shra", 32'h8000_0001, 32'd1, 4'd7, 1'b0, 64'h0000_0000_C000_0000);
        alu_chk("shl", 32'h8000_0001, 32'd1, 4'd8, 1'b0, 64'h0000_0000_0000_0002);
        alu_chk("rol", 32'h8000_0001, 32'd1, 4'd9, 1'b0, 64'h0000_0000_0000_0003);
        alu_chk("ror0", 32'h8000_0001, 32'd0, 4'd10, 1'b0, 64'h0000_0000_8000_0001);
        alu_chk("add", 32'd5, 32'd7, 4'd0, 1'b0, 64'd12);
        alu_chk("sub", 32'd5, 32'd7, 4'd1, 1'b0, 64'h0000_0000_FFFF_FFFE);
        alu_chk("and", 32'hF0F0_1234, 32'h0FF0_FF00, 4'd2, 1'b0, 64'h0000_0000_00F0_1200);
        alu_chk("or", 32'hF000_0001, 32'h0000_0F00, 4'd3, 1'b0, 64'h0000_0000_F000_0F01);
        alu_chk("neg", 32'd0, 32'd5, 4'd11, 1'b0, 64'h0000_0000_FFFF_FFFB);
        alu_chk("not", 32'd0, 32'h0F0F_0000, 4'd12, 1'b0, 64'h0000_0000_F0F0_FFFF);
        alu_chk("op13", 32'd9, 32'd9, 4'd13, 1'b0, 64'd0);
        alu_chk("incwrap", 32'd9, 32'hFFFF_FFFF, 4'd4, 1'b1, 64'd0);

        // Two enables on one edge both capture the same bus value.
        load_mdr(32'h0000_55AA);
        dp.BusDataSelect = 5'd21;
        dp.e_HI          = 1'b1;
        dp.e_LO          = 1'b1;
        step();
        chk_bus("dual_hi", 5'd16, 32'h0000_55AA);
        chk_bus("dual_lo", 5'd17, 32'h0000_55AA);

        // Bus select sweep over distinct preloaded values.
        for (int i = 0; i < 16; i++) put_gp(i[3:0], 32'hC0DE_0000 | i);
        load_mdr(32'h4849_0000);
        dp.BusDataSelect = 5'd21; dp.e_HI = 1'b1; step();
        load_mdr(32'h4C4F_0000);
        dp.BusDataSelect = 5'd21; dp.e_LO = 1'b1; step();
        load_mdr(32'h5043_0000);
        dp.BusDataSelect = 5'd21; dp.e_PC = 1'b1; step();
        load_mdr(32'h4952_0000);
        dp.BusDataSelect = 5'd21; dp.e_IR = 1'b1; step();
        load_mdr(32'h4D44_5200);
        dp.BusDataSelect = 5'd21; dp.incPC = 1'b1; dp.e_Z = 1'b1; step();
        for (int s = 0; s < 32; s++) begin
            if (s < 16)       exp_s = 32'hC0DE_0000 | s;
            else if (s == 16) exp_s = 32'h4849_0000;
            else if (s == 17) exp_s = 32'h4C4F_0000;
            else if (s == 19) exp_s = 32'h4D44_5201;
            else if (s == 20) exp_s = 32'h5043_0000;
            else if (s == 21) exp_s = 32'h4D44_5200;
            else if (s == 22) exp_s = 32'h4952_0000;
            else              exp_s = 32'd0;
            chk_bus($sformatf("sweep_sel%0d", s), s[4:0], exp_s);
        end
        dp.BusDataSelect = 5'd20;
        dp.e_MAR         = 1'b1;
        step();
        chk("mar_from_pc", {32'd0, dp.MARout}, 64'h0000_0000_5043_0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
